// File: rtl/aludec_pipe.sv
// Pipelined ALU control decoder with a one-entry valid/ready output stage and an
// optional multi-cycle MUL path, enabled by defining ALUDEC_MUL_EN.
module aludec_pipe #(
    parameter int FUNCT_W = 11,
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [1:0]         aluop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  alucontrol,
    output logic               illegal,
    output logic               busy
);

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FULL  = 2'd1,
        MULTI = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       ill;
    } dec_t;

    // Reject out-of-range parameters at elaboration time.
    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
        $error("aludec_pipe: MUL_LAT must be in 1..15");
    end
    if (FUNCT_W < 11) begin : g_bad_funct_w
        $error("aludec_pipe: FUNCT_W must be at least 11");
    end
    if (CTRL_W < 4) begin : g_bad_ctrl_w
        $error("aludec_pipe: CTRL_W must be at least 4");
    end

    // Single-cycle decode; MUL is not listed here and is steered separately.
    function automatic dec_t decode(input logic [1:0] op, input logic [10:0] f);
        dec_t d;
        d.ctrl = 4'b0000;
        d.ill  = 1'b1;
        case (op)
            2'b00: begin
                d.ctrl = 4'b0010;
                d.ill  = 1'b0;
            end
            2'b01: begin
                d.ctrl = 4'b0111;
                d.ill  = 1'b0;
            end
            2'b10: begin
                case (f)
                    OP_ADD: begin
                        d.ctrl = 4'b0010;
                        d.ill  = 1'b0;
                    end
                    OP_SUB: begin
                        d.ctrl = 4'b0110;
                        d.ill  = 1'b0;
                    end
                    OP_AND: begin
                        d.ctrl = 4'b0000;
                        d.ill  = 1'b0;
                    end
                    OP_ORR: begin
                        d.ctrl = 4'b0001;
                        d.ill  = 1'b0;
                    end
                    default: begin
                        d.ctrl = 4'b0000;
                        d.ill  = 1'b1;
                    end
                endcase
            end
            2'b11: begin
                if (f[10:1] == OP_ADDI) begin
                    d.ctrl = 4'b0010;
                    d.ill  = 1'b0;
                end else begin
                    d.ctrl = 4'b0000;
                    d.ill  = 1'b1;
                end
            end
            default: begin
                d.ctrl = 4'b0000;
                d.ill  = 1'b1;
            end
        endcase
        return d;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CTRL_W-1:0]  ctrl_r;
    logic [CTRL_W-1:0]  ctrl_nxt_s;
    logic               illegal_r;
    logic               illegal_nxt_s;
    logic               accept_s;
    dec_t               dec_s;

`ifdef ALUDEC_MUL_EN
    localparam logic [10:0] OP_MUL = 11'b10011011000;
    localparam int          CNT_W  = $clog2(MUL_LAT + 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             is_mul_s;

    assign is_mul_s = (aluop == 2'b10) && (funct[10:0] == OP_MUL);
`endif

    assign dec_s     = decode(aluop, funct[10:0]);
    assign in_ready  = (state_r == IDLE) || ((state_r == FULL) && out_ready);
    assign out_valid = (state_r == FULL);
    assign accept_s  = in_valid && in_ready;
`ifdef ALUDEC_MUL_EN
    assign busy      = (state_r == MULTI);
`else
    assign busy      = 1'b0;
`endif
    assign alucontrol = ctrl_r;
    assign illegal    = illegal_r;

    // Next-state and output-register logic for the IDLE/FULL/MULTI controller.
    always_comb begin
        state_nxt_s   = state_r;
        ctrl_nxt_s    = ctrl_r;
        illegal_nxt_s = illegal_r;
`ifdef ALUDEC_MUL_EN
        cnt_nxt_s     = cnt_r;
`endif
        case (state_r)
            IDLE, FULL: begin
                if (accept_s) begin
`ifdef ALUDEC_MUL_EN
                    if (is_mul_s) begin
                        state_nxt_s = MULTI;
                        cnt_nxt_s   = CNT_W'(MUL_LAT - 1);
                    end else begin
                        state_nxt_s   = FULL;
                        ctrl_nxt_s    = CTRL_W'(dec_s.ctrl);
                        illegal_nxt_s = dec_s.ill;
                    end
`else
                    state_nxt_s   = FULL;
                    ctrl_nxt_s    = CTRL_W'(dec_s.ctrl);
                    illegal_nxt_s = dec_s.ill;
`endif
                end else if ((state_r == FULL) && out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            MULTI: begin
`ifdef ALUDEC_MUL_EN
                // Counter saturates at zero; the result is published on that edge.
                if (cnt_r == '0) begin
                    state_nxt_s   = FULL;
                    ctrl_nxt_s    = CTRL_W'(4'b1000);
                    illegal_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
`else
                state_nxt_s = IDLE;
`endif
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and registered decode outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            ctrl_r    <= '0;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ctrl_r    <= ctrl_nxt_s;
            illegal_r <= illegal_nxt_s;
        end
    end

`ifdef ALUDEC_MUL_EN
    // MUL latency counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`endif

endmodule
